// File: rtl/timer_pkg.sv
// Shared types for the two-digit BCD countdown controller.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSED,
    EXPIRED
  } timer_state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that produces one tick every TICK_DIV advanced cycles.
// The count holds when advance is low, so a pause simply freezes the phase.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic advance,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  // Count advanced cycles, wrapping at TICK_DIV-1; clear wins over advance.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (advance)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = advance && (cnt == LAST);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Control for a 99..00 BCD countdown built from two external down counters:
// captures the start value, loads the counters, issues the per-period count
// enables, chains tens from the units terminal count and stops at 00.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       pause,
  input  logic       restart,
  input  logic [3:0] start_tens,
  input  logic [3:0] start_units,
  input  logic       tc_units,
  input  logic       tc_tens,
  output logic       loadN,
  output logic [3:0] datain_tens,
  output logic [3:0] datain_units,
  output logic       cnt_ena_units,
  output logic       cnt_ena_tens,
  output logic       running,
  output logic       paused,
  output logic       timeout,
  output logic       expired
);

  timer_state_t state, nxt;
  bcd_t         cap_tens, cap_units;
  logic         expired_q;
  logic         advance;
  logic         tick;
  logic         zero;

  assign zero = tc_units && tc_tens;

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Next state and prescaler advance. The cycle that leaves PAUSED already
  // counts as running time, so a pause input held P cycles costs exactly P.
  always_comb begin
    nxt     = state;
    advance = 1'b0;
    unique case (state)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    nxt = RUN;
      RUN: begin
        if (restart)    nxt = LOAD;
        else if (zero)  nxt = EXPIRED;
        else if (pause) nxt = PAUSED;
        else            advance = 1'b1;
      end
      PAUSED: begin
        if (restart) nxt = LOAD;
        else if (!pause) begin
          nxt     = RUN;
          advance = !zero;
        end
      end
      EXPIRED: if (start || restart) nxt = LOAD;
      default: nxt = IDLE;
    endcase
  end

  // Start value is captured on every entry into LOAD.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cap_tens  <= '0;
      cap_units <= '0;
    end else if (nxt == LOAD) begin
      cap_tens  <= start_tens;
      cap_units <= start_units;
    end
  end

  // One-cycle pulse in the first EXPIRED cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      expired_q <= 1'b0;
    else
      expired_q <= (nxt == EXPIRED) && (state != EXPIRED);
  end

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk     (clk),
    .resetN  (resetN),
    .clear   (state == LOAD),
    .advance (advance),
    .tick    (tick)
  );

  assign cnt_ena_units = tick;
  assign cnt_ena_tens  = tick && tc_units;

  assign loadN        = (state != LOAD);
  assign datain_tens  = cap_tens;
  assign datain_units = cap_units;
  assign running      = (state == RUN);
  assign paused       = (state == PAUSED);
  assign timeout      = (state == EXPIRED);
  assign expired      = expired_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench: controller plus two behavioural BCD down counters.
module tb_countdown_timer_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0, pause = 1'b0, restart = 1'b0;
  logic [3:0] start_tens = 4'd0, start_units = 4'd0;
  logic       tc_units, tc_tens, loadN;
  logic [3:0] datain_tens, datain_units;
  logic       cnt_ena_units, cnt_ena_tens;
  logic       running, paused, timeout, expired;
  logic [3:0] cu, ct;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .start         (start),
    .pause         (pause),
    .restart       (restart),
    .start_tens    (start_tens),
    .start_units   (start_units),
    .tc_units      (tc_units),
    .tc_tens       (tc_tens),
    .loadN         (loadN),
    .datain_tens   (datain_tens),
    .datain_units  (datain_units),
    .cnt_ena_units (cnt_ena_units),
    .cnt_ena_tens  (cnt_ena_tens),
    .running       (running),
    .paused        (paused),
    .timeout       (timeout),
    .expired       (expired)
  );

  // Units down counter: load, else decrement with 0 -> 9 wrap.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)            cu <= 4'd0;
    else if (!loadN)        cu <= datain_units;
    else if (cnt_ena_units) cu <= (cu == 4'd0) ? 4'd9 : cu - 4'd1;
  end

  // Tens down counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           ct <= 4'd0;
    else if (!loadN)       ct <= datain_tens;
    else if (cnt_ena_tens) ct <= (ct == 4'd0) ? 4'd9 : ct - 4'd1;
  end

  assign tc_units = (cu == 4'd0);
  assign tc_tens  = (ct == 4'd0);

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Status vector order: loadN, running, paused, timeout, expired.
  task automatic st(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, loadN, running, paused, timeout, expired}, {27'd0, exp});
  endtask

  // One full tick period starting with the prescaler at 0 and count v.
  task automatic period(input int v);
    for (int i = 0; i < TD - 1; i++) begin
      chk("ena_idle_phase", {cnt_ena_units, cnt_ena_tens}, 2'b00);
      step();
    end
    chk("ena_units_wrap", cnt_ena_units, 1'b1);
    chk("ena_tens_wrap", cnt_ena_tens, (v % 10 == 0));
    step();
    chk("count_after_tick", {ct, cu}, bcd(v - 1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #2;
    st("reset_status", 5'b10000);
    chk("reset_datain", {datain_tens, datain_units}, 8'h00);
    chk("reset_ena", {cnt_ena_units, cnt_ena_tens}, 2'b00);
    #10 resetN = 1'b1;
    step();
    st("idle_status", 5'b10000);

    // Start 12: full countdown to 00, no wrap
    start_tens = 4'd1; start_units = 4'd2; start = 1'b1;
    step();
    start = 1'b0; #1;
    st("s12_load", 5'b00000);
    chk("s12_datain", {datain_tens, datain_units}, 8'h12);
    step();
    st("s12_run", 5'b11000);
    chk("s12_loaded", {ct, cu}, 8'h12);
    for (int v = 12; v >= 1; v--) period(v);
    chk("s12_zero_no_ena", {cnt_ena_units, cnt_ena_tens}, 2'b00);
    st("s12_zero_run", 5'b11000);
    step();
    st("s12_expired_pulse", 5'b10011);
    step();
    st("s12_timeout_hold", 5'b10010);
    repeat (4) step();
    chk("s12_no_wrap", {ct, cu}, 8'h00);
    st("s12_still_timeout", 5'b10010);

    // Start 00 from EXPIRED: expires on first RUN cycle with no enable
    start_tens = 4'd0; start_units = 4'd0; start = 1'b1;
    step();
    start = 1'b0; #1;
    st("s00_load", 5'b00000);
    step();
    st("s00_run", 5'b11000);
    chk("s00_no_ena", {cnt_ena_units, cnt_ena_tens}, 2'b00);
    step();
    st("s00_expired", 5'b10011);
    chk("s00_no_ena2", {cnt_ena_units, cnt_ena_tens}, 2'b00);

    // Start 05 with a 7-cycle pause after the first tick
    start_tens = 4'd0; start_units = 4'd5; start = 1'b1;
    step();
    start = 1'b0; #1;
    st("s05_load", 5'b00000);
    step();
    chk("s05_loaded", {ct, cu}, 8'h05);
    period(5);
    pause = 1'b1; #1;
    st("s05_pause_req", 5'b11000);
    chk("s05_pause_no_ena", cnt_ena_units, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      st("s05_paused", 5'b10100);
      chk("s05_paused_no_ena", cnt_ena_units, 1'b0);
    end
    chk("s05_count_held", {ct, cu}, 8'h04);
    step();
    pause = 1'b0; #1;
    st("s05_paused_last", 5'b10100);
    chk("s05_exit_no_ena", cnt_ena_units, 1'b0);
    step();
    st("s05_resumed", 5'b11000);
    chk("s05_r1_no_ena", cnt_ena_units, 1'b0);
    step();
    chk("s05_r2_no_ena", cnt_ena_units, 1'b0);
    step();
    chk("s05_late_tick", cnt_ena_units, 1'b1);
    step();
    chk("s05_count_03", {ct, cu}, 8'h03);

    // Restart: reload 08, tick to 07, then restart with 30 on a wrap cycle
    start_tens = 4'd0; start_units = 4'd8; restart = 1'b1; #1;
    chk("r_restart_no_ena", cnt_ena_units, 1'b0);
    step();
    restart = 1'b0; #1;
    st("r_load08", 5'b00000);
    step();
    chk("r_loaded08", {ct, cu}, 8'h08);
    period(8);
    repeat (TD - 1) step();
    start_tens = 4'd3; start_units = 4'd0; restart = 1'b1; #1;
    chk("r_restart_beats_tick", cnt_ena_units, 1'b0);
    step();
    restart = 1'b0; #1;
    st("r_load30", 5'b00000);
    chk("r_datain30", {datain_tens, datain_units}, 8'h30);
    chk("r_count_still07", {ct, cu}, 8'h07);
    step();
    chk("r_loaded30", {ct, cu}, 8'h30);
    period(30);

    // Reset mid-run at count 03
    start_tens = 4'd0; start_units = 4'd4; restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    chk("rst_loaded04", {ct, cu}, 8'h04);
    period(4);
    step(); step();
    #1 resetN = 1'b0;
    #1;
    st("rst_async_status", 5'b10000);
    chk("rst_async_datain", {datain_tens, datain_units}, 8'h00);
    chk("rst_async_ena", {cnt_ena_units, cnt_ena_tens}, 2'b00);
    #1 resetN = 1'b1;
    step();
    st("rst_idle", 5'b10000);
    chk("rst_idle_ena", {cnt_ena_units, cnt_ena_tens}, 2'b00);
    repeat (3) step();
    st("rst_idle_stays", 5'b10000);

    // start and pause together in IDLE
    start_tens = 4'd2; start_units = 4'd1; start = 1'b1; pause = 1'b1;
    step();
    start = 1'b0; #1;
    st("sp_load", 5'b00000);
    step();
    st("sp_run", 5'b11000);
    chk("sp_run_no_ena", cnt_ena_units, 1'b0);
    chk("sp_loaded21", {ct, cu}, 8'h21);
    step();
    st("sp_paused", 5'b10100);
    repeat (3) step();
    st("sp_paused_hold", 5'b10100);
    chk("sp_count_held", {ct, cu}, 8'h21);
    pause = 1'b0; #1;
    chk("sp_exit_no_ena", cnt_ena_units, 1'b0);
    step();
    chk("sp_a_no_ena", cnt_ena_units, 1'b0);
    step();
    chk("sp_b_no_ena", cnt_ena_units, 1'b0);
    step();
    chk("sp_tick", cnt_ena_units, 1'b1);
    step();
    chk("sp_count20", {ct, cu}, 8'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
